// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader: FSM states, slot count,
// and the debounce counter sizing helper.
package operand_loader_pkg;

  localparam int NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/operand_loader_if.sv
// Operand/handshake bundle between the operand loader (master) and the
// 4-input processing block (slave): four operand slots plus 4-phase req/ack.
interface operand_loader_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] op0;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] op3;
  logic              req;
  logic              ack;

  modport master (output op0, op1, op2, op3, req, input ack);
  modport slave  (input op0, op1, op2, op3, req, output ack);
endinterface

// File: rtl/operand_loader_sw_debounce.sv
// Single-switch conditioner: 2-flop synchroniser, stable-count debounce and a
// one-cycle registered pulse on each debounced 0->1 transition.
module sw_debounce
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // The edge that would bring the count to DEBOUNCE_CYCLES commits the new
  // level instead, so the counter tops out at DEBOUNCE_CYCLES-1 and cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Operand loader: debounced slot selects load a nibble into each operand slot;
// a full set (or a go press when OPERAND_LOADER_PARTIAL_GO_EN is defined)
// is offered to the block through a 4-phase req/ack transaction.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DATA_W          = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    sw_data,
  input  logic [NUM_SLOTS-1:0] sw_sel,
`ifdef OPERAND_LOADER_PARTIAL_GO_EN
  input  logic                 sw_go,
`endif
  operand_loader_if.master     blk,
  output logic [NUM_SLOTS-1:0] loaded,
  output logic                 busy,
  output logic                 err
);

  state_t               state, state_n;
  logic [DATA_W-1:0]    data_s1, data_s2;
  logic [DATA_W-1:0]    op_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] sel_rise;
  logic [NUM_SLOTS-1:0] pick;
  logic [NUM_SLOTS-1:0] load_en;
  logic [NUM_SLOTS-1:0] loaded_n;
  logic                 multi;
  logic                 any_rise;
  logic                 err_n;

  genvar g;
  generate
    for (g = 0; g < NUM_SLOTS; g++) begin : g_sel
      sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (sw_sel[g]),
        .rise (sel_rise[g])
      );
    end
  endgenerate

`ifdef OPERAND_LOADER_PARTIAL_GO_EN
  logic go_rise;

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_go (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (sw_go),
    .rise (go_rise)
  );

  assign any_rise = (sel_rise != '0) || go_rise;
`else
  assign any_rise = (sel_rise != '0);
`endif

  // Lowest set bit wins; anything else rising alongside it is dropped.
  assign pick  = sel_rise & (~sel_rise + NUM_SLOTS'(1));
  assign multi = (sel_rise & ~pick) != '0;

  always_comb begin
    state_n  = state;
    loaded_n = loaded;
    load_en  = '0;
    err_n    = 1'b0;
    case (state)
      COLLECT: begin
        if (sel_rise != '0) begin
          load_en  = pick;
          loaded_n = loaded | pick;
          err_n    = multi;
        end
`ifdef OPERAND_LOADER_PARTIAL_GO_EN
        if (go_rise) begin
          if (loaded != '0) state_n = ISSUE;
          else              err_n   = 1'b1;
        end
`endif
        if (loaded_n == '1) state_n = ISSUE;
      end
      ISSUE: begin
        err_n = any_rise;
        if (blk.ack) state_n = RELEASE;
      end
      RELEASE: begin
        err_n = any_rise;
        if (!blk.ack) begin
          loaded_n = '0;
          state_n  = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      loaded  <= '0;
      err     <= 1'b0;
      data_s1 <= '0;
      data_s2 <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) op_q[i] <= '0;
    end else begin
      state   <= state_n;
      loaded  <= loaded_n;
      err     <= err_n;
      data_s1 <= sw_data;
      data_s2 <= data_s1;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (load_en[i]) op_q[i] <= data_s2;
      end
    end
  end

  assign blk.op0 = op_q[0];
  assign blk.op1 = op_q[1];
  assign blk.op2 = op_q[2];
  assign blk.op3 = op_q[3];
  assign blk.req = (state == ISSUE);
  assign busy    = (state != COLLECT);

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: transaction-level model predicts load,
// issue, completion and error events; a forked monitor checks them.
module tb_operand_loader;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_data;
  logic [3:0] sw_sel;
`ifdef OPERAND_LOADER_PARTIAL_GO_EN
  logic       sw_go;
`endif
  logic [3:0] loaded;
  logic       busy;
  logic       err;

  operand_loader_if #(.DATA_W(4)) bif ();

  operand_loader #(.DEBOUNCE_CYCLES(D), .DATA_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_data(sw_data),
    .sw_sel (sw_sel),
`ifdef OPERAND_LOADER_PARTIAL_GO_EN
    .sw_go  (sw_go),
`endif
    .blk    (bif),
    .loaded (loaded),
    .busy   (busy),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ld;
    logic [15:0] ops;
  } snap_t;

  snap_t load_q[$];
  snap_t req_q[$];
  snap_t done_q[$];
  bit    err_q[$];

  int vectors     = 0;
  int miscompares = 0;
  bit expect_short = 1'b0;

  logic [3:0] m_loaded;
  logic [3:0] m_ops [4];
  bit         m_busy;

  function automatic snap_t model_snap();
    return {m_loaded, m_ops[3], m_ops[2], m_ops[1], m_ops[0]};
  endfunction

  function automatic snap_t dut_snap();
    return {loaded, bif.op3, bif.op2, bif.op1, bif.op0};
  endfunction

  function automatic int lowest(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) if (mask[i]) return i;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loaded = '0;
    m_busy   = 1'b0;
    for (int i = 0; i < 4; i++) m_ops[i] = '0;
  endtask

  task automatic model_sel(input logic [3:0] mask, input logic [3:0] d);
    int lo;
    if (mask == 0) return;
    if (m_busy) begin
      err_q.push_back(1'b1);
      return;
    end
    lo = lowest(mask);
    if ($countones(mask) > 1) err_q.push_back(1'b1);
    m_ops[lo] = d;
    if (!m_loaded[lo]) begin
      m_loaded[lo] = 1'b1;
      load_q.push_back(model_snap());
    end
    if (m_loaded == 4'hF) begin
      req_q.push_back(model_snap());
      m_busy = 1'b1;
    end
  endtask

  task automatic model_go();
    if (m_busy || m_loaded == 0) begin
      err_q.push_back(1'b1);
    end else begin
      req_q.push_back(model_snap());
      m_busy = 1'b1;
    end
  endtask

  task automatic model_done();
    m_loaded = '0;
    m_busy   = 1'b0;
    done_q.push_back(model_snap());
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] mask, input logic [3:0] d, input int hold);
    if (hold >= D) model_sel(mask, d);
    sw_data = d;
    sw_sel  = mask;
    idle(hold);
    sw_sel = '0;
    idle(D + 6);
  endtask

`ifdef OPERAND_LOADER_PARTIAL_GO_EN
  task automatic press_go();
    model_go();
    sw_go = 1'b1;
    idle(D + 4);
    sw_go = 1'b0;
    idle(D + 6);
  endtask
`endif

  task automatic wait_req(input logic v, input string name);
    int n = 0;
    while (bif.req !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bif.req), 32'(v));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic v, input string name);
    int n = 0;
    while (busy !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'(v));
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name, input bit empty, input snap_t e);
    if (empty) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: unexpected event, got 0x%0h expected none at %0t", name, dut_snap(), $time);
    end else begin
      check(name, 32'(dut_snap()), 32'(e));
    end
  endtask

  task automatic monitor();
    logic [3:0] pl;
    logic       pr;
    logic       pb;
    int         rlen;
    snap_t      e;
    pl = '0; pr = 1'b0; pb = 1'b0; rlen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pl = '0; pr = 1'b0; pb = 1'b0; rlen = 0;
      end else begin
        if (loaded != pl && loaded != 0) begin
          e = (load_q.size() > 0) ? load_q.pop_front() : '0;
          pop_check("load_event", load_q.size() == 0 && e == '0, e);
        end
        if (bif.req && !pr) begin
          e = (req_q.size() > 0) ? req_q.pop_front() : '0;
          pop_check("req_event", e == '0, e);
          check("req_busy", 32'(busy), 32'd1);
        end
        if (!busy && pb) begin
          e = (done_q.size() > 0) ? done_q.pop_front() : {4'hF, 16'h0};
          pop_check("done_event", e == {4'hF, 16'h0}, e);
        end
        if (err) begin
          vectors++;
          if (err_q.size() == 0) begin
            miscompares++;
            $display("FAIL err_event: got err=1 expected err=0 at %0t", $time);
          end else begin
            void'(err_q.pop_front());
          end
        end
        if (bif.req) begin
          rlen++;
        end else if (pr) begin
          if (expect_short) begin
            check("req_width", 32'(rlen), 32'd1);
            expect_short = 1'b0;
          end
          rlen = 0;
        end
        pl = loaded;
        pr = bif.req;
        pb = busy;
      end
    end
  endtask

  task automatic finish_txn(input bit early);
    if (early) begin
      wait_req(1'b0, "req_early_drop");
    end else begin
      wait_req(1'b1, "req_rise");
      if ($urandom_range(0, 1) == 1) press(4'b1 << $urandom_range(0, 3), 4'($urandom), D + 4);
      bif.ack = 1'b1;
      idle(1);
      check("req_drop_after_ack", 32'(bif.req), 32'd0);
      if ($urandom_range(0, 1) == 1) press(4'($urandom_range(1, 15)), 4'($urandom), D + 4);
    end
    bif.ack = 1'b0;
    model_done();
    wait_busy(1'b0, "busy_release");
  endtask

  task automatic random_txn();
    bit         early;
    int         guard;
    logic [3:0] mask;
    logic [3:0] d;
    early = 1'b0;
    guard = 0;
    while (!m_busy && guard < 40) begin
      guard++;
      mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) != 0) mask = 4'b1 << $urandom_range(0, 3);
      d = 4'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        press(mask, d, $urandom_range(1, D - 1));
      end else begin
        if (((m_loaded | (4'b1 << lowest(mask))) == 4'hF) && $urandom_range(0, 2) == 0) begin
          early        = 1'b1;
          expect_short = 1'b1;
          bif.ack      = 1'b1;
        end
        press(mask, d, D + 4 + $urandom_range(0, 3));
      end
    end
    if (m_busy) finish_txn(early);
  endtask

  initial begin
    rst_n   = 1'b0;
    sw_data = '0;
    sw_sel  = '0;
    bif.ack = 1'b0;
`ifdef OPERAND_LOADER_PARTIAL_GO_EN
    sw_go = 1'b0;
`endif
    model_reset();
    fork
      monitor();
    join_none

    #3;
    check("reset_outputs", 32'({bif.req, busy, err, dut_snap()}), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Latency: slot 2 must load on exactly the 7th edge after the first sample.
    model_sel(4'b0100, 4'hA);
    sw_data = 4'hA;
    sw_sel  = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) check("latency_early", 32'(loaded), 32'd0);
    end
    check("latency_loaded", 32'(loaded), 32'b0100);
    check("latency_op2", 32'(bif.op2), 32'hA);
    idle(2);
    sw_sel = '0;
    idle(D + 6);

    press(4'b0010, 4'h7, 2);
    check("glitch_no_load", 32'(loaded), 32'b0100);

    press(4'b0001, 4'h1, D + 4);
    press(4'b0010, 4'h2, D + 4);
    press(4'b0100, 4'h3, D + 4);
    press(4'b1000, 4'h4, D + 4);
    wait_req(1'b1, "req_full");
    check("busy_issue", 32'(busy), 32'd1);
    press(4'b0001, 4'hE, D + 4);
    bif.ack = 1'b1;
    idle(1);
    check("req_drop_after_ack", 32'(bif.req), 32'd0);
    check("busy_release", 32'(busy), 32'd1);
    press(4'b0010, 4'h9, D + 4);
    bif.ack = 1'b0;
    model_done();
    wait_busy(1'b0, "busy_done");
    check("ops_retained", 32'(dut_snap()), 32'h04321);

    press(4'b1010, 4'h6, D + 4);
    check("simul_slot1", 32'(loaded), 32'b0010);

    press(4'b0001, 4'h8, D + 4);
    press(4'b0100, 4'hB, D + 4);
    expect_short = 1'b1;
    bif.ack      = 1'b1;
    press(4'b1000, 4'hC, D + 4);
    finish_txn(1'b1);

    // Asynchronous reset in the middle of an issued transaction.
    for (int i = 0; i < 4; i++) press(4'b1 << i, 4'($urandom_range(1, 15)), D + 4);
    wait_req(1'b1, "req_before_reset");
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", 32'({bif.req, busy, dut_snap()}), 32'd0);
    model_reset();
    idle(1);
    rst_n = 1'b1;
    idle(2);
    check("post_reset_collect", 32'({bif.req, busy}), 32'd0);

    for (int t = 0; t < 6; t++) random_txn();

`ifdef OPERAND_LOADER_PARTIAL_GO_EN
    rst_n = 1'b0;
    model_reset();
    idle(1);
    rst_n = 1'b1;
    idle(2);
    press_go();
    check("go_empty_no_req", 32'({bif.req, busy}), 32'd0);
    press(4'b0001, 4'h5, D + 4);
    press_go();
    wait_req(1'b1, "go_req");
    check("go_partial_ops", 32'(dut_snap()), 32'h10005);
    bif.ack = 1'b1;
    idle(1);
    bif.ack = 1'b0;
    model_done();
    wait_busy(1'b0, "go_busy_done");
`endif

    idle(5);
    check("load_q_drained", 32'(load_q.size()), 32'd0);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    check("err_q_drained", 32'(err_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream stage of the 4-input processing block; sits between the raw switch inputs and the block's four 4-bit operand inputs.
- Synchronises and debounces the four slot-select switches, and loads a 4-bit nibble into the slot whose select rises.
- Once all four slots are loaded, issues a 4-phase req/ack transaction to the block; operands are frozen for the whole transaction.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synced cycles required before a debounced select level changes; legal range 1..255.
- DATA_W, 4: operand nibble width.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw_data  in  DATA_W  raw operand switches.
- sw_sel  in  4  raw slot-select switches; bit i selects slot i.
- ack  in  1  block ready/acknowledge, 4-phase.
- op0, op1, op2, op3  out  DATA_W each  operand slots to the block.
- loaded  out  4  per-slot loaded flags.
- req  out  1  operands valid / request.
- busy  out  1  high in ISSUE and RELEASE.
- err  out  1  one-cycle pulse on a rejected select edge.

Behaviour:
- Reset is asynchronous assert and synchronous deassert at the clk domain. On reset:
  - op0..op3 = 0, loaded = 0, req = 0, busy = 0, err = 0.
  - State = COLLECT.
  - Synchronisers, debounced levels and counters = 0.
- sw_data and sw_sel each pass through 2-flop synchronisers.
- Debounce, per sel bit: the counter increments while synced != debounced and clears when they are equal. When the counter reaches DEBOUNCE_CYCLES, debounced takes the synced value and the counter clears. A debounced 0->1 transition produces a one-cycle rise pulse.
- Latency: from the first clk edge sampling sw_sel[i]=1 (stably held) to loaded[i]/op_i updated is exactly DEBOUNCE_CYCLES+3 edges. The written value is the synced sw_data in the rise-pulse cycle.
- States:
  - COLLECT:
    - A rise pulse on sel i writes op_i and sets loaded[i]. Reloading an already-loaded slot overwrites it.
    - Multiple simultaneous rise pulses: the lowest index wins, the others are dropped, and err pulses.
    - When loaded becomes 4'hF, the next state is ISSUE.
  - ISSUE:
    - req=1, busy=1; op_i frozen.
    - Rise pulses are ignored and each pulses err.
    - ack=1 sampled -> RELEASE.
  - RELEASE:
    - req=0, busy=1.
    - ack=0 sampled -> clear loaded, go to COLLECT; op_i retain their values.
    - Rise pulses are rejected with err.
- ack already high on ISSUE entry: req still asserts for at least 1 cycle, then RELEASE.
- ack high in COLLECT: ignored.
- Reset mid-transaction: req drops immediately (async); no completion is owed.
- Counter width = clog2(DEBOUNCE_CYCLES+1); it never wraps.

Optional Feature:
- Macro: OPERAND_LOADER_PARTIAL_GO_EN.
- Defined:
  - Adds input sw_go (1 bit), synchronised and debounced identically to sw_sel.
  - A go rise pulse in COLLECT with loaded != 0 forces ISSUE; unloaded slots present their current op value.
  - A go rise with loaded == 0 pulses err.
  - A go rise outside COLLECT pulses err.
- Undefined: no sw_go port; ISSUE is entered only on loaded == 4'hF.

Decomposition:
- Package operand_loader_pkg:
  - State enum {COLLECT, ISSUE, RELEASE}, 2 bits.
  - Debounce counter-width function.
  - NUM_SLOTS = 4 constant.
- Sub-module sw_debounce: 2-flop sync + stable counter + rise pulse, parameterised by DEBOUNCE_CYCLES. Four instances, plus one for sw_go when enabled.

Test Plan:
- Reset mid-ISSUE with req=1: assert rst_n=0 -> req, loaded, op* all 0 with no clock edge; state COLLECT after release.
- DEBOUNCE_CYCLES=4; sw_data=4'hA, hold sw_sel[2]=1 -> op2=4'hA and loaded=4'b0100 exactly 7 edges after first sample. A 2-cycle glitch on sw_sel[1] -> no load.
- Load slots 0..3 with 1,2,3,4 -> req=1 with op0..op3=1,2,3,4 and busy=1.
  - ack=1 -> req=0 next cycle.
  - ack=0 -> loaded=0, busy=0, op values retained.
- sw_sel[3] and sw_sel[1] rise together -> only slot 1 loaded, err pulses 1 cycle. A select rise during ISSUE -> op unchanged, err pulse.
- ack held high before issue -> req high for exactly 1 cycle, then RELEASE; the transaction completes when ack falls.
- OPERAND_LOADER_PARTIAL_GO_EN defined:
  - Load only slot 0=5, then a sw_go rise -> req=1 with op0=5, op1..op3=0.
  - sw_go rise with loaded=0 -> err pulse, no req.
